// File: rtl/kf8259_common_pkg.sv
// Shared types and helpers for the KF8259 interrupt sequencer: state encoding,
// circular priority rotation and lowest-index one-hot resolution.
package kf8259_common_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } sequencer_state_t;

  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  // Moves the highest-priority level (bottom+1) down to bit 0.
  function automatic logic [7:0] rotate_right(input logic [7:0] bits, input logic [2:0] bottom);
    logic [7:0] result;
    logic [2:0] src;
    result = 8'h00;
    for (int i = 0; i < 8; i++) begin
      src       = 3'(i) + bottom + 3'd1;
      result[i] = bits[src];
    end
    return result;
  endfunction

  function automatic logic [7:0] rotate_left(input logic [7:0] bits, input logic [2:0] bottom);
    logic [7:0] result;
    logic [2:0] dst;
    result = 8'h00;
    for (int i = 0; i < 8; i++) begin
      dst         = 3'(i) + bottom + 3'd1;
      result[dst] = bits[i];
    end
    return result;
  endfunction

  function automatic logic [7:0] resolve(input logic [7:0] bits);
    logic [7:0] result;
    logic       found;
    result = 8'h00;
    found  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bits[i] && !found) begin
        result[i] = 1'b1;
        found     = 1'b1;
      end else begin
        found     = found;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/kf8259_rotating_priority_encoder.sv
// Picks the highest-priority set bit of an 8-bit vector under circular
// priority, where bottom is the lowest-priority level.
module kf8259_rotating_priority_encoder
  import kf8259_common_pkg::*;
(
  input  logic [7:0] request,
  input  logic [2:0] bottom,
  output logic       valid,
  output logic [2:0] level
);

  logic [7:0] one_hot_s;

  // Resolve in rotated space, then map the winner back to its real level.
  always_comb begin
    one_hot_s = rotate_left(resolve(rotate_right(request, bottom)), bottom);
    valid     = |request;
    level     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (one_hot_s[i]) begin
        level = 3'(i);
      end else begin
        level = level;
      end
    end
  end

endmodule

// File: rtl/kf8259_interrupt_sequencer.sv
// KF8259 priority resolver, INTA sequencer and in-service register owner.
// Optional feature: define KF8259_AUTO_EOI_EN to add the auto_eoi_config input.
module kf8259_interrupt_sequencer
  import kf8259_common_pkg::*;
#(
  parameter logic [2:0] RESET_BOTTOM_PRIORITY = 3'd7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt_request_register,
  input  logic [7:0] interrupt_mask,
  input  logic [4:0] vector_base,
  input  logic       interrupt_acknowledge_n,
  input  logic       eoi_strobe,
  input  logic       eoi_specific,
  input  logic       eoi_rotate,
  input  logic [2:0] eoi_level,
  input  logic       set_priority_strobe,
  input  logic [2:0] set_priority_level,
`ifdef KF8259_AUTO_EOI_EN
  input  logic       auto_eoi_config,
`endif
  output logic       freeze,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] in_service_register,
  output logic       interrupt,
  output logic [7:0] vector_out,
  output logic       vector_valid
);

  sequencer_state_t state_r, state_next_s;
  logic       inta_prev_r, falling_s, rising_s;
  logic [2:0] bottom_r, bottom_next_s, latched_level_r;
  logic       spurious_r;
  logic [7:0] isr_r, isr_next_s, set_mask_s, clear_mask_s, auto_clear_s;
  logic       freeze_r, freeze_next_s, vector_valid_r, vector_valid_next_s;
  logic       interrupt_r, interrupt_next_s;
  logic [7:0] clear_request_r, vector_out_r;
  logic       req_valid_s, isr_valid_s;
  logic [2:0] req_level_s, isr_level_s, req_rank_s, isr_rank_s;
  logic       capture_s, deliver_s, finish_s;

  kf8259_rotating_priority_encoder u_request_encoder (
    .request (interrupt_request_register & ~interrupt_mask),
    .bottom  (bottom_r),
    .valid   (req_valid_s),
    .level   (req_level_s)
  );

  kf8259_rotating_priority_encoder u_service_encoder (
    .request (isr_r),
    .bottom  (bottom_r),
    .valid   (isr_valid_s),
    .level   (isr_level_s)
  );

  assign falling_s = inta_prev_r & ~interrupt_acknowledge_n;
  assign rising_s  = ~inta_prev_r & interrupt_acknowledge_n;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // Next-state logic driven by INTA edges.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (falling_s) state_next_s = ACK1;  else state_next_s = IDLE;
      ACK1:    if (rising_s)  state_next_s = WAIT2; else state_next_s = ACK1;
      WAIT2:   if (falling_s) state_next_s = ACK2;  else state_next_s = WAIT2;
      ACK2:    if (rising_s)  state_next_s = IDLE;  else state_next_s = ACK2;
      default: state_next_s = IDLE;
    endcase
  end

  // Output, ISR and priority next-values; EOI clear is applied before the ISR set.
  always_comb begin
    capture_s = (state_r == IDLE)  && falling_s;
    deliver_s = (state_r == WAIT2) && falling_s;
    finish_s  = (state_r == ACK2)  && rising_s;
    req_rank_s = req_level_s - bottom_r - 3'd1;
    isr_rank_s = isr_level_s - bottom_r - 3'd1;
    freeze_next_s       = (state_next_s != IDLE);
    vector_valid_next_s = (state_next_s == ACK2);
    interrupt_next_s    = (state_next_s == IDLE) && req_valid_s &&
                          (!isr_valid_s || (req_rank_s < isr_rank_s));
`ifdef KF8259_AUTO_EOI_EN
    if (finish_s && auto_eoi_config && !spurious_r) auto_clear_s = 8'd1 << latched_level_r;
    else                                            auto_clear_s = 8'h00;
`else
    auto_clear_s = 8'h00;
`endif
    if (deliver_s && !spurious_r) set_mask_s = 8'd1 << latched_level_r;
    else                          set_mask_s = 8'h00;
    clear_mask_s  = auto_clear_s;
    bottom_next_s = bottom_r;
    if (eoi_strobe && eoi_specific) begin
      clear_mask_s = clear_mask_s | (8'd1 << eoi_level);
      if (eoi_rotate) bottom_next_s = eoi_level;
      else            bottom_next_s = bottom_r;
    end else if (eoi_strobe && isr_valid_s) begin
      clear_mask_s = clear_mask_s | (8'd1 << isr_level_s);
      if (eoi_rotate) bottom_next_s = isr_level_s;
      else            bottom_next_s = bottom_r;
    end else begin
      clear_mask_s = clear_mask_s;
    end
    if (set_priority_strobe) bottom_next_s = set_priority_level;
    else                     bottom_next_s = bottom_next_s;
    isr_next_s = (isr_r & ~clear_mask_s) | set_mask_s;
  end

  // Registered datapath and outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inta_prev_r     <= 1'b1;
      bottom_r        <= RESET_BOTTOM_PRIORITY;
      latched_level_r <= 3'd0;
      spurious_r      <= 1'b0;
      isr_r           <= 8'h00;
      freeze_r        <= 1'b0;
      vector_valid_r  <= 1'b0;
      interrupt_r     <= 1'b0;
      clear_request_r <= 8'h00;
      vector_out_r    <= 8'h00;
    end else begin
      inta_prev_r     <= interrupt_acknowledge_n;
      bottom_r        <= bottom_next_s;
      isr_r           <= isr_next_s;
      freeze_r        <= freeze_next_s;
      vector_valid_r  <= vector_valid_next_s;
      interrupt_r     <= interrupt_next_s;
      clear_request_r <= set_mask_s;
      if (capture_s) begin
        latched_level_r <= req_valid_s ? req_level_s : SPURIOUS_LEVEL;
        spurious_r      <= ~req_valid_s;
      end
      if (deliver_s) vector_out_r <= {vector_base, latched_level_r};
    end
  end

  assign freeze                  = freeze_r;
  assign clear_interrupt_request = clear_request_r;
  assign in_service_register     = isr_r;
  assign interrupt               = interrupt_r;
  assign vector_out              = vector_out_r;
  assign vector_valid            = vector_valid_r;

endmodule

// File: doc/kf8259_interrupt_sequencer.md
# kf8259_interrupt_sequencer

Acknowledge and priority sequencer for the KF8259 interrupt controller. Sits between the interrupt request register and the CPU bus interface. It resolves the highest-priority unmasked request against the in-service register, drives INT, and runs the two-pulse 8086 INTA sequence (freeze, vector, ISR set, IRR clear). It also owns the in-service register and executes EOI and rotation commands.

## Interface
- RESET_BOTTOM_PRIORITY, default 3'd7: lowest-priority level after reset, so IR0 is highest.
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- interrupt_request_register  in  8  IRR bits
- interrupt_mask  in  8  IMR; 1 = masked
- vector_base  in  5  T7..T3 of the vector byte
- interrupt_acknowledge_n  in  1  INTA pin, already synchronous to clock
- eoi_strobe  in  1  one-cycle EOI command
- eoi_specific  in  1  1 = use eoi_level; 0 = non-specific
- eoi_rotate  in  1  1 = rotate priority on this EOI
- eoi_level  in  3  level for specific EOI
- set_priority_strobe  in  1  one-cycle set-priority command
- set_priority_level  in  3  new bottom-priority level
- freeze  out  1  hold IRR (to the request block)
- clear_interrupt_request  out  8  one-hot, one-cycle IRR clear
- in_service_register  out  8  ISR
- interrupt  out  1  INT to CPU, registered
- vector_out  out  8  {vector_base, level}
- vector_valid  out  1  vector_out is driven

## Operation
- Priority order is circular: highest = bottom+1, lowest = bottom (mod 8).
- Request winner: highest-priority bit of IRR & ~IMR.
- Fully nested rule: interrupt = 1 if the winner is strictly higher priority than the highest ISR bit, or if ISR = 0.
- INTA edges are detected from a one-cycle delayed copy (prev_n); a falling edge is prev_n=1 with current 0.
- States:
  - IDLE: on falling edge -> ACK1. freeze=1; latch the winner level. If there is no valid winner, latch 7 and set the spurious flag.
  - ACK1: on rising edge -> WAIT2.
  - WAIT2: on falling edge -> ACK2. vector_out = {vector_base, latched}; vector_valid=1. If not spurious, set ISR[latched] and pulse clear_interrupt_request[latched].
  - ACK2: on rising edge -> IDLE. freeze=0; vector_valid=0.
- interrupt is forced to 0 from ACK1 through ACK2.
- EOI, accepted in any state:
  - Non-specific: clears the highest-priority ISR bit; no-op if ISR=0.
  - Specific: clears ISR[eoi_level].
  - eoi_rotate=1: bottom := cleared level. For non-specific with ISR=0, no rotation.
- set_priority_strobe: bottom := set_priority_level.
- Collisions:
  - EOI clear and ISR set in the same cycle: clear applied first, then set, so set wins on the same bit.
  - EOI rotate and set_priority in the same cycle: set_priority wins.

## Timing
- Reset values: state IDLE, ISR 0, bottom = RESET_BOTTOM_PRIORITY, interrupt 0, freeze 0, clear_interrupt_request 0, vector_out 0, vector_valid 0.
- interrupt updates 1 cycle after an IRR, IMR, or ISR change.
- Edge detection costs 1 cycle. freeze rises 1 cycle after the sampled INTA falls.
- clear_interrupt_request and the ISR bit assert 1 cycle after the second falling edge. The clear pulse is exactly 1 cycle.
- vector_valid rises with the ISR update and falls 1 cycle after the sampled INTA rises.
- Reset mid-sequence: returns immediately to reset values. freeze drops, so the IRR is released.

## Configuration
- KF8259_AUTO_EOI_EN defined: adds input auto_eoi_config (1 bit).
  - If auto_eoi_config=1, the ISR bit set in ACK2 is cleared on the ACK2 -> IDLE transition, with no rotation.
  - interrupt re-evaluates the cycle after.
- KF8259_AUTO_EOI_EN undefined: port absent; ISR is cleared only by EOI commands.

## Structure
- Shared package kf8259_common_pkg holds:
  - state enum {IDLE, ACK1, WAIT2, ACK2};
  - functions rotate_right(bits, bottom), rotate_left(bits, bottom), and lowest-index one-hot resolve;
  - constant SPURIOUS_LEVEL = 3'd7.
- Sub-module kf8259_rotating_priority_encoder (8-bit vector + bottom -> valid, level) is instantiated twice: once for IRR & ~IMR, once for ISR.

## Test plan
- IRR=0x04, IMR=0, ISR=0; two INTA pulses, vector_base=0x08 -> interrupt=1; vector_out=0x42; ISR=0x04; clear_interrupt_request=0x04 for 1 cycle.
- ISR=0x04, IRR=0x10 -> interrupt stays 0. Raise IRR bit 1 -> interrupt=1.
- IRR drops to 0 between the two INTA pulses -> vector_out low bits=7; ISR unchanged; no clear pulse.
- ISR=0x06, non-specific EOI with rotate -> ISR=0x04, bottom=1; IR2 is now highest priority.
- Reset asserted in WAIT2 -> freeze=0, ISR=0, state IDLE next cycle. Then KF8259_AUTO_EOI_EN with auto_eoi_config=1: after ACK2 the ISR returns to 0.
